ccff_chain_loader: RTL and testbench

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

---
 rtl/ccff_chain_loader_pkg.sv | 31 +++
 rtl/ccff_word_serializer.sv | 64 ++++++
 rtl/ccff_chain_loader.sv | 177 +++++++++++++++++
 tb/tb_ccff_chain_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_chain_loader_pkg.sv
// -----------------------------------------------------------------------------
// ccff_chain_loader_pkg
//
// Purpose:
//   Shared definitions for the configuration-chain loader: the FSM state
//   encoding, default chain/word geometry, and a helper that sizes counters.
//
// Contents:
//   DEF_CHAIN_LEN  default number of flops in the downstream ccff chain
//   DEF_WORD_W     default width of one configuration word
//   state_t        loader FSM states
//   cnt_width()    width of a counter that must hold 0 .. n-1 (never 0 bits)
// -----------------------------------------------------------------------------
package ccff_chain_loader_pkg;

    localparam int DEF_CHAIN_LEN = 22;
    localparam int DEF_WORD_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_WORD = 2'd1,
        ST_SHIFT     = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    // A one-entry range still needs a 1-bit counter so the ports stay legal.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// -----------------------------------------------------------------------------
// ccff_word_serializer
//
// Purpose:
//   Holds one configuration word and presents it LSB-first, one bit per
//   shift request. Tracks how many bits of the current word have been shifted
//   so the loader knows when to fetch the next word.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_n_i  asynchronous active-low reset
//   load_i   capture data_i into the word register and restart the bit count
//   data_i   configuration word
//   shift_i  advance one bit (word register shifts right, count increments)
//   bit0_o   current serial bit (word register bit 0, a flop output)
//   last_o   the bit currently on bit0_o is the final bit of the word
// -----------------------------------------------------------------------------
module ccff_word_serializer
    import ccff_chain_loader_pkg::*;
#(
    parameter  int WORD_W = DEF_WORD_W,
    localparam int WCNT_W = cnt_width(WORD_W)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              load_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              shift_i,
    output logic              bit0_o,
    output logic              last_o
);

    localparam logic [WCNT_W-1:0] LAST_CNT = WCNT_W'(WORD_W - 1);

    logic [WORD_W-1:0] word_q, word_d;
    logic [WCNT_W-1:0] cnt_q,  cnt_d;

    // Load takes priority; the loader never asserts both in the same cycle.
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            word_d = data_i;
            cnt_d  = '0;
        end else if (shift_i) begin
            word_d = word_q >> 1;
            cnt_d  = cnt_q + WCNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bit0_o = word_q[0];
    assign last_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/ccff_chain_loader.sv
// -----------------------------------------------------------------------------
// ccff_chain_loader
//
// Purpose:
//   Streams configuration words into a serial configuration-flop chain of
//   CHAIN_LEN flops, LSB of each word first. In load mode it only writes the
//   chain; in verify mode it writes the chain again while comparing the bit
//   leaving the chain tail with the bit entering the head, recording the
//   index of the first disagreement. Exactly CHAIN_LEN bits are shifted per
//   pass; surplus bits of the last word are dropped.
//
// Ports:
//   prog_clk      clock, rising edge
//   prog_reset    asynchronous active-low reset
//   start         one-cycle request to begin a pass (honoured only when idle)
//   mode          0 = load, 1 = verify; sampled together with start
//   cfg_data      configuration word
//   cfg_valid     cfg_data is valid
//   cfg_ready     loader accepts cfg_data this cycle
//   ccff_head     serial bit into the chain head
//   ccff_clk_en   chain clock-gate enable; the chain shifts only when 1
//   ccff_tail     serial bit out of the chain tail
//   busy          a pass is in progress
//   done          one-cycle pulse at the end of a pass
//   mismatch      sticky verify failure flag
//   mismatch_idx  chain bit index of the first verify failure
// -----------------------------------------------------------------------------
module ccff_chain_loader
    import ccff_chain_loader_pkg::*;
#(
    parameter  int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter  int WORD_W    = DEF_WORD_W,
    localparam int IDX_W     = cnt_width(CHAIN_LEN)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              mode,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_clk_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              mismatch,
    output logic [IDX_W-1:0]  mismatch_idx
);

    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(CHAIN_LEN - 1);

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [IDX_W-1:0] bitcnt_q, bitcnt_d;
    logic             mm_q, mm_d;
    logic [IDX_W-1:0] mm_idx_q, mm_idx_d;
    logic             clk_en_q, clk_en_d;

    logic             word_load;
    logic             word_shift;
    logic             ser_bit0;
    logic             ser_last;

    // -------------------------------------------------------------------------
    // Word serializer: one word register feeding the chain head
    // -------------------------------------------------------------------------
    assign word_load  = (state_q == ST_WAIT_WORD) && cfg_valid;
    assign word_shift = (state_q == ST_SHIFT);

    ccff_word_serializer #(
        .WORD_W (WORD_W)
    ) u_ser (
        .clk_i   (prog_clk),
        .rst_n_i (prog_reset),
        .load_i  (word_load),
        .data_i  (cfg_data),
        .shift_i (word_shift),
        .bit0_o  (ser_bit0),
        .last_o  (ser_last)
    );

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        bitcnt_d = bitcnt_q;
        mm_d     = mm_q;
        mm_idx_d = mm_idx_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_WAIT_WORD;
                    mode_d   = mode;
                    bitcnt_d = '0;
                    mm_d     = 1'b0;
                    mm_idx_d = '0;
                end
            end

            ST_WAIT_WORD: begin
                // cfg_ready is high throughout this state, so valid alone
                // completes the handshake.
                if (cfg_valid) begin
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                bitcnt_d = bitcnt_q + IDX_W'(1);

                // Head and tail are both observed on the edge that shifts the
                // chain, so bit n entering the head lines up with the old
                // bit n leaving the tail.
                if (mode_q && !mm_q && (ccff_head != ccff_tail)) begin
                    mm_d     = 1'b1;
                    mm_idx_d = bitcnt_q;
                end

                // Chain-length check wins so surplus bits of the final word
                // never reach the chain.
                if (bitcnt_q == LAST_BIT) begin
                    state_d = ST_DONE;
                end else if (ser_last) begin
                    state_d = ST_WAIT_WORD;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The enable is registered so the chain clock gate sees a clean flop.
        clk_en_d = (state_d == ST_SHIFT);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge prog_clk or negedge prog_reset) begin
        if (!prog_reset) begin
            state_q  <= ST_IDLE;
            mode_q   <= 1'b0;
            bitcnt_q <= '0;
            mm_q     <= 1'b0;
            mm_idx_q <= '0;
            clk_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            bitcnt_q <= bitcnt_d;
            mm_q     <= mm_d;
            mm_idx_q <= mm_idx_d;
            clk_en_q <= clk_en_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all decoded from flops)
    // -------------------------------------------------------------------------
    assign cfg_ready    = (state_q == ST_WAIT_WORD);
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign ccff_head    = ser_bit0;
    assign ccff_clk_en  = clk_en_q;
    assign mismatch     = mm_q;
    assign mismatch_idx = mm_idx_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// -----------------------------------------------------------------------------
// tb_ccff_chain_loader
//
// Bench for ccff_chain_loader with a 22-flop chain clocked on ccff_clk_en.
// Expected chain contents are given as a 22-bit "stream" value whose bit i is
// the i-th bit shifted into the chain head.
// -----------------------------------------------------------------------------
module tb_ccff_chain_loader;

    localparam int CL = 22;
    localparam int WW = 8;

    logic          prog_clk = 1'b0;
    logic          prog_reset;
    logic          start;
    logic          mode;
    logic [WW-1:0] cfg_data;
    logic          cfg_valid;
    logic          cfg_ready;
    logic          ccff_head;
    logic          ccff_clk_en;
    logic          ccff_tail;
    logic          busy;
    logic          done;
    logic          mismatch;
    logic [4:0]    mismatch_idx;

    ccff_chain_loader #(
        .CHAIN_LEN (CL),
        .WORD_W    (WW)
    ) dut (
        .prog_clk     (prog_clk),
        .prog_reset   (prog_reset),
        .start        (start),
        .mode         (mode),
        .cfg_data     (cfg_data),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .ccff_head    (ccff_head),
        .ccff_clk_en  (ccff_clk_en),
        .ccff_tail    (ccff_tail),
        .busy         (busy),
        .done         (done),
        .mismatch     (mismatch),
        .mismatch_idx (mismatch_idx)
    );

    always #5 prog_clk = ~prog_clk;

    // Chain model plus event counters.
    logic [CL-1:0] chain   = '0;
    int            n_en    = 0;
    int            n_words = 0;
    int            n_done  = 0;

    assign ccff_tail = chain[CL-1];

    always @(posedge prog_clk) begin
        if (ccff_clk_en) begin
            chain <= {chain[CL-2:0], ccff_head};
            n_en  <= n_en + 1;
        end
        if (cfg_valid && cfg_ready) n_words <= n_words + 1;
        if (done) n_done <= n_done + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int en0, wd0, dn0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    function automatic logic [CL-1:0] stream_of(input logic [CL-1:0] c);
        logic [CL-1:0] s;
        for (int i = 0; i < CL; i++) s[i] = c[CL-1-i];
        return s;
    endfunction

    // One full pass. poke=1 pulses start (with mode=1) while the pass is busy.
    task automatic run_pass(input logic m, input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2, input int stall, input logic poke);
        logic [7:0] w[3];
        int guard;
        w[0] = w0; w[1] = w1; w[2] = w2;
        en0 = n_en; wd0 = n_words; dn0 = n_done;
        @(negedge prog_clk);
        start = 1'b1; mode = m;
        @(negedge prog_clk);
        start = 1'b0; mode = 1'b0;
        chk("mismatch_cleared_at_start", mismatch, 0);
        chk("busy_after_start", busy, 1);
        for (int k = 0; k < 3; k++) begin
            guard = 0;
            while (!cfg_ready && guard < 40) begin
                if (poke && guard == 2) begin start = 1'b1; mode = 1'b1; end
                else begin start = 1'b0; mode = 1'b0; end
                @(negedge prog_clk);
                guard++;
            end
            start = 1'b0; mode = 1'b0;
            if (!cfg_ready) timeout("wait_cfg_ready");
            if (k > 0) begin
                for (int s = 0; s < stall; s++) begin
                    chk("stall_clk_en", ccff_clk_en, 0);
                    chk("stall_cfg_ready", cfg_ready, 1);
                    @(negedge prog_clk);
                end
            end
            cfg_data = w[k]; cfg_valid = 1'b1;
            start = poke; mode = poke;
            @(negedge prog_clk);
            cfg_valid = 1'b0; start = 1'b0; mode = 1'b0;
        end
        guard = 0;
        while (n_done == dn0 && guard < 100) begin
            @(negedge prog_clk);
            guard++;
        end
        if (n_done == dn0) timeout("wait_done");
        repeat (3) @(negedge prog_clk);
        chk("busy_after_done", busy, 0);
        chk("done_after_done", done, 0);
    endtask

    task automatic check_pass(input string tag, input logic [CL-1:0] exp_stream,
                              input logic exp_mm, input logic [4:0] exp_idx);
        chk({tag, "_enabled_edges"}, n_en - en0, CL);
        chk({tag, "_words"}, n_words - wd0, 3);
        chk({tag, "_done_pulses"}, n_done - dn0, 1);
        chk({tag, "_mismatch"}, mismatch, exp_mm);
        chk({tag, "_mismatch_idx"}, mismatch_idx, exp_idx);
        chk({tag, "_chain"}, stream_of(chain), exp_stream);
    endtask

    typedef struct {
        logic          m;
        logic [7:0]    w0, w1, w2;
        int            stall;
        logic [CL-1:0] exp_stream;
        logic          exp_mm;
        logic [4:0]    exp_idx;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int en_r, guard;
        string tag;

        tbl[0] = '{1'b0, 8'hA5, 8'h3C, 8'h2F, 0, 22'h2F3CA5, 1'b0, 5'd0};  // load
        tbl[1] = '{1'b0, 8'hA5, 8'h3C, 8'h2F, 5, 22'h2F3CA5, 1'b0, 5'd0};  // load with stalls
        tbl[2] = '{1'b1, 8'hA5, 8'h3C, 8'h2F, 0, 22'h2F3CA5, 1'b0, 5'd0};  // verify ok
        tbl[3] = '{1'b1, 8'hA5, 8'h3D, 8'h2F, 0, 22'h2F3DA5, 1'b1, 5'd8};  // bit 8 differs
        tbl[4] = '{1'b1, 8'hA5, 8'h3D, 8'h2F, 2, 22'h2F3DA5, 1'b0, 5'd0};  // chain now holds 0x3D
        tbl[5] = '{1'b0, 8'h00, 8'h00, 8'h00, 0, 22'h000000, 1'b0, 5'd0};  // load zeros
        tbl[6] = '{1'b1, 8'hFF, 8'hFF, 8'hFF, 0, 22'h3FFFFF, 1'b1, 5'd0};  // fails at bit 0
        tbl[7] = '{1'b1, 8'hFF, 8'hFF, 8'h3F, 0, 22'h3FFFFF, 1'b0, 5'd0};  // bits 22,23 dropped
        tbl[8] = '{1'b1, 8'hFF, 8'hFF, 8'hC0, 0, 22'h00FFFF, 1'b1, 5'd16}; // last-word fail

        prog_reset = 1'b0; start = 1'b0; mode = 1'b0; cfg_data = '0; cfg_valid = 1'b0;
        repeat (2) @(negedge prog_clk);
        chk("rst_cfg_ready", cfg_ready, 0);
        chk("rst_ccff_head", ccff_head, 0);
        chk("rst_ccff_clk_en", ccff_clk_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mismatch", mismatch, 0);
        chk("rst_mismatch_idx", mismatch_idx, 0);
        prog_reset = 1'b1;
        repeat (2) @(negedge prog_clk);
        chk("idle_busy", busy, 0);

        for (int i = 0; i < 9; i++) begin
            run_pass(tbl[i].m, tbl[i].w0, tbl[i].w1, tbl[i].w2, tbl[i].stall, 1'b0);
            tag = $sformatf("vec%0d", i);
            check_pass(tag, tbl[i].exp_stream, tbl[i].exp_mm, tbl[i].exp_idx);
            if (i == 0) chk("vec0_chain_bits", chain, 22'b10100101_00111100_111101);
        end

        // Reset in the middle of a load pass, after 10 bits have been shifted.
        en0 = n_en;
        @(negedge prog_clk);
        start = 1'b1; mode = 1'b0;
        @(negedge prog_clk);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            guard = 0;
            while (!cfg_ready && guard < 40) begin
                @(negedge prog_clk);
                guard++;
            end
            if (!cfg_ready) timeout("rst_wait_cfg_ready");
            cfg_data = (k == 0) ? 8'hA5 : 8'h3C; cfg_valid = 1'b1;
            @(negedge prog_clk);
            cfg_valid = 1'b0;
        end
        guard = 0;
        while ((n_en - en0) < 10 && guard < 40) begin
            @(negedge prog_clk);
            guard++;
        end
        chk("pre_reset_edges", n_en - en0, 10);
        chk("pre_reset_clk_en", ccff_clk_en, 1);
        chk("pre_reset_head", ccff_head, 1);
        prog_reset = 1'b0;
        #1;
        chk("midrst_cfg_ready", cfg_ready, 0);
        chk("midrst_ccff_head", ccff_head, 0);
        chk("midrst_ccff_clk_en", ccff_clk_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_mismatch", mismatch, 0);
        chk("midrst_mismatch_idx", mismatch_idx, 0);
        en_r = n_en;
        repeat (4) @(negedge prog_clk);
        chk("midrst_no_edges", n_en, en_r);
        prog_reset = 1'b1;
        repeat (4) @(negedge prog_clk);
        chk("after_rst_no_edges", n_en, en_r);
        chk("after_rst_busy", busy, 0);

        // Fresh known chain, then a load pass with start pulsed while busy.
        run_pass(1'b0, 8'h00, 8'h00, 8'h00, 0, 1'b0);
        check_pass("reload", 22'h000000, 1'b0, 5'd0);
        run_pass(1'b0, 8'hA5, 8'h3C, 8'h2F, 0, 1'b1);
        check_pass("start_ignored", 22'h2F3CA5, 1'b0, 5'd0);
        run_pass(1'b1, 8'hA5, 8'h3C, 8'h2F, 1, 1'b0);
        check_pass("final_verify", 22'h2F3CA5, 1'b0, 5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
